// File: rtl/tx_64_framer.sv
// tx_64_framer
// Store-and-forward UDP transmit framer. Takes one send request (destination
// IP and ports) and a 64-bit AXIS payload from the application. The whole
// payload is buffered so its byte count is known before anything goes out.
// The framer then emits a 112-bit UDP header carrying that length, followed
// by the buffered payload.
//
// Ports
//   ap_clk, ap_rst_n            clock, synchronous active-low reset
//   tx_req_V_*                  send request {dest_port, src_port, dest_ip}
//   tx_payload_*                application payload (AXIS, 64-bit)
//   udp_header_V_*              {length, dest_port, src_port, dest_ip, src_ip}
//   udp_payload_*               payload toward the UDP/IP stack
//   stat_sent                   frames fully sent (wraps)
//   stat_drop                   one-cycle pulse per dropped frame
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a send request
// ACCUM  | buffering payload beats and counting bytes
// HDR    | presenting the UDP header
// DRAIN  | forwarding buffered beats
// DROP   | discarding the rest of an oversize frame up to its tlast
module tx_64_framer #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] LOCAL_IP = 32'h0A00_0001
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic [63:0]   tx_req_V_TDATA,
    input  logic          tx_req_V_TVALID,
    output logic          tx_req_V_TREADY,
    input  logic [63:0]   tx_payload_TDATA,
    input  logic [7:0]    tx_payload_TKEEP,
    input  logic          tx_payload_TLAST,
    input  logic          tx_payload_TUSER,
    input  logic          tx_payload_TVALID,
    output logic          tx_payload_TREADY,
    output logic [111:0]  udp_header_V_TDATA,
    output logic          udp_header_V_TVALID,
    input  logic          udp_header_V_TREADY,
    output logic [63:0]   udp_payload_TDATA,
    output logic [7:0]    udp_payload_TKEEP,
    output logic          udp_payload_TLAST,
    output logic          udp_payload_TUSER,
    output logic          udp_payload_TVALID,
    input  logic          udp_payload_TREADY,
    output logic [31:0]   stat_sent,
    output logic          stat_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_HDR,
        S_DRAIN,
        S_DROP
    } state_t;

    state_t        state_q;
    logic [63:0]   req_q;
    logic [16:0]   bytes_q, bytes_d;
    logic          err_q, err_d;
    logic          req_rdy_q, pay_rdy_q, hdr_vld_q, drop_q;
    logic [31:0]   sent_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;

    // FIFO entry layout: {tdata[72:9], tkeep[8:1], tlast[0]}
    logic [72:0]   mem [DEPTH];
    logic [72:0]   head;
    logic [AW:0]   fill;
    logic          full, empty;
    logic          pay_acc, wr_en, out_vld, out_hs;
    logic [3:0]    beat_bytes;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fill       = wr_ptr_q - rd_ptr_q;
    assign full       = (fill == FULL_CNT);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign head       = mem[rd_ptr_q[AW-1:0]];

    assign pay_acc    = pay_rdy_q & tx_payload_TVALID;
    assign wr_en      = (state_q == S_ACCUM) & pay_acc & ~full;
    assign out_vld    = (state_q == S_DRAIN) & ~empty;
    assign out_hs     = out_vld & udp_payload_TREADY;

    assign beat_bytes = popcount8(tx_payload_TKEEP);
    assign bytes_d    = bytes_q + {13'd0, beat_bytes};
    assign err_d      = err_q | tx_payload_TUSER;

    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {tx_payload_TDATA, tx_payload_TKEEP, tx_payload_TLAST};
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            bytes_q   <= '0;
            err_q     <= 1'b0;
            req_rdy_q <= 1'b0;
            pay_rdy_q <= 1'b0;
            hdr_vld_q <= 1'b0;
            drop_q    <= 1'b0;
            sent_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_rdy_q <= 1'b1;
                    if (req_rdy_q && tx_req_V_TVALID) begin
                        req_q     <= tx_req_V_TDATA;
                        bytes_q   <= '0;
                        err_q     <= 1'b0;
                        req_rdy_q <= 1'b0;
                        pay_rdy_q <= 1'b1;
                        state_q   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (pay_acc) begin
                        if (full) begin
                            // Oversize: nothing of this frame can be sent.
                            wr_ptr_q <= rd_ptr_q;
                            if (tx_payload_TLAST) begin
                                drop_q    <= 1'b1;
                                pay_rdy_q <= 1'b0;
                                req_rdy_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end else begin
                                state_q <= S_DROP;
                            end
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            bytes_q  <= bytes_d;
                            err_q    <= err_d;
                            if (tx_payload_TLAST) begin
                                pay_rdy_q <= 1'b0;
                                if (err_d) begin
                                    // Overrides the write-pointer advance above.
                                    wr_ptr_q  <= rd_ptr_q;
                                    drop_q    <= 1'b1;
                                    req_rdy_q <= 1'b1;
                                    state_q   <= S_IDLE;
                                end else begin
                                    hdr_vld_q <= 1'b1;
                                    state_q   <= S_HDR;
                                end
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (pay_acc && tx_payload_TLAST) begin
                        drop_q    <= 1'b1;
                        pay_rdy_q <= 1'b0;
                        req_rdy_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_HDR: begin
                    if (udp_header_V_TREADY) begin
                        hdr_vld_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        if (head[0]) begin
                            sent_q    <= sent_q + 32'd1;
                            req_rdy_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_req_V_TREADY     = req_rdy_q;
    assign tx_payload_TREADY   = pay_rdy_q;
    assign udp_header_V_TVALID = hdr_vld_q;
    // Length is the UDP header (8 bytes) plus the payload, kept to 16 bits.
    assign udp_header_V_TDATA  = {16'(bytes_q + 17'd8), req_q[63:48], req_q[47:32],
                                  req_q[31:0], LOCAL_IP};
    assign udp_payload_TVALID  = out_vld;
    assign udp_payload_TDATA   = head[72:9];
    assign udp_payload_TKEEP   = head[8:1];
    assign udp_payload_TLAST   = head[0];
    assign udp_payload_TUSER   = 1'b0;
    assign stat_sent           = sent_q;
    assign stat_drop           = drop_q;

endmodule

// File: tb/tb_tx_64_framer.sv
`timescale 1ns/1ps
module tb_tx_64_framer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] LIP   = 32'h0A00_0001;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [63:0]   tx_req_V_TDATA = '0;
    logic          tx_req_V_TVALID = 1'b0;
    logic          tx_req_V_TREADY;
    logic [63:0]   tx_payload_TDATA = '0;
    logic [7:0]    tx_payload_TKEEP = '0;
    logic          tx_payload_TLAST = 1'b0;
    logic          tx_payload_TUSER = 1'b0;
    logic          tx_payload_TVALID = 1'b0;
    logic          tx_payload_TREADY;
    logic [111:0]  udp_header_V_TDATA;
    logic          udp_header_V_TVALID;
    logic          udp_header_V_TREADY = 1'b0;
    logic [63:0]   udp_payload_TDATA;
    logic [7:0]    udp_payload_TKEEP;
    logic          udp_payload_TLAST;
    logic          udp_payload_TUSER;
    logic          udp_payload_TVALID;
    logic          udp_payload_TREADY = 1'b0;
    logic [31:0]   stat_sent;
    logic          stat_drop;

    always #5 ap_clk = ~ap_clk;

    tx_64_framer #(.DEPTH(DEPTH), .LOCAL_IP(LIP)) dut (
        .ap_clk              (ap_clk),
        .ap_rst_n            (ap_rst_n),
        .tx_req_V_TDATA      (tx_req_V_TDATA),
        .tx_req_V_TVALID     (tx_req_V_TVALID),
        .tx_req_V_TREADY     (tx_req_V_TREADY),
        .tx_payload_TDATA    (tx_payload_TDATA),
        .tx_payload_TKEEP    (tx_payload_TKEEP),
        .tx_payload_TLAST    (tx_payload_TLAST),
        .tx_payload_TUSER    (tx_payload_TUSER),
        .tx_payload_TVALID   (tx_payload_TVALID),
        .tx_payload_TREADY   (tx_payload_TREADY),
        .udp_header_V_TDATA  (udp_header_V_TDATA),
        .udp_header_V_TVALID (udp_header_V_TVALID),
        .udp_header_V_TREADY (udp_header_V_TREADY),
        .udp_payload_TDATA   (udp_payload_TDATA),
        .udp_payload_TKEEP   (udp_payload_TKEEP),
        .udp_payload_TLAST   (udp_payload_TLAST),
        .udp_payload_TUSER   (udp_payload_TUSER),
        .udp_payload_TVALID  (udp_payload_TVALID),
        .udp_payload_TREADY  (udp_payload_TREADY),
        .stat_sent           (stat_sent),
        .stat_drop           (stat_drop)
    );

    int total = 0;
    int bad = 0;
    int sent_exp = 0;

    typedef struct {
        logic [63:0] req;
        int          nbeats;
        logic [7:0]  last_keep;
        int          err_beat;   // 1-based beat carrying TUSER, 0 = none
        logic [15:0] exp_len;
        bit          exp_drop;
        int          mode;       // 0 = output always ready, 1 = ready toggles
    } vec_t;

    vec_t vecs[7];

    function automatic logic [63:0] beat_data(input int f, input int b);
        return {32'hD00D_0000 + 32'(f), 32'hB000_0000 + 32'(b)} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_frame(input int f, input vec_t v);
        int n;
        tx_req_V_TDATA  = v.req;
        tx_req_V_TVALID = 1'b1;
        n = 0;
        while (!tx_req_V_TREADY && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        chk("req_ready", tx_req_V_TREADY, 1);
        @(negedge ap_clk);
        tx_req_V_TVALID = 1'b0;
        chk("pay_ready_after_req", tx_payload_TREADY, 1);
        for (int b = 0; b < v.nbeats; b++) begin
            tx_payload_TDATA  = beat_data(f, b);
            tx_payload_TKEEP  = (b == v.nbeats - 1) ? v.last_keep : 8'hFF;
            tx_payload_TLAST  = (b == v.nbeats - 1);
            tx_payload_TUSER  = (b + 1 == v.err_beat);
            tx_payload_TVALID = 1'b1;
            n = 0;
            while (!tx_payload_TREADY && n < 50) begin
                @(negedge ap_clk);
                n++;
            end
            chk("beat_accept", tx_payload_TREADY, 1);
            @(negedge ap_clk);
        end
        tx_payload_TVALID = 1'b0;
        tx_payload_TLAST  = 1'b0;
        tx_payload_TUSER  = 1'b0;
    endtask

    task automatic check_out(input int f, input vec_t v);
        logic [111:0] exp_hdr;
        logic [73:0]  hold_val;
        bit           held;
        bit           rdy;
        bit           el;
        int           got;
        int           cyc;
        exp_hdr = {v.exp_len, v.req[63:48], v.req[47:32], v.req[31:0], LIP};
        chk("hdr_valid", udp_header_V_TVALID, 1);
        chk("hdr_data", udp_header_V_TDATA, exp_hdr);
        @(negedge ap_clk);
        chk("hdr_hold", {udp_header_V_TVALID, udp_header_V_TDATA}, {1'b1, exp_hdr});
        udp_header_V_TREADY = 1'b1;
        @(negedge ap_clk);
        udp_header_V_TREADY = 1'b0;
        chk("hdr_done", udp_header_V_TVALID, 0);
        chk("first_beat_valid", udp_payload_TVALID, 1);
        got = 0;
        cyc = 0;
        held = 1'b0;
        hold_val = '0;
        while (got < v.nbeats && cyc < 100) begin
            if (held) begin
                chk("stall_hold", {udp_payload_TVALID, udp_payload_TDATA, udp_payload_TKEEP,
                                   udp_payload_TLAST}, hold_val);
                held = 1'b0;
            end
            rdy = (v.mode == 0) || ((cyc % 2) == 1);
            udp_payload_TREADY = rdy;
            if (udp_payload_TVALID) begin
                if (rdy) begin
                    el = (got == v.nbeats - 1);
                    chk("beat_data", udp_payload_TDATA, beat_data(f, got));
                    chk("beat_keep", udp_payload_TKEEP, el ? v.last_keep : 8'hFF);
                    chk("beat_last", udp_payload_TLAST, el);
                    chk("beat_user", udp_payload_TUSER, 0);
                    got++;
                end else begin
                    held = 1'b1;
                    hold_val = {udp_payload_TVALID, udp_payload_TDATA, udp_payload_TKEEP,
                                udp_payload_TLAST};
                end
            end
            @(negedge ap_clk);
            cyc++;
        end
        udp_payload_TREADY = 1'b0;
        chk("beat_count", got, v.nbeats);
        sent_exp++;
        chk("stat_sent", stat_sent, sent_exp);
        chk("drain_end_valid", udp_payload_TVALID, 0);
        chk("drain_end_reqrdy", tx_req_V_TREADY, 1);
        chk("drain_no_drop", stat_drop, 0);
    endtask

    task automatic run_vec(input int f, input vec_t v);
        drive_frame(f, v);
        if (v.exp_drop) begin
            chk("drop_pulse", stat_drop, 1);
            chk("drop_no_hdr", udp_header_V_TVALID, 0);
            @(negedge ap_clk);
            chk("drop_pulse_end", stat_drop, 0);
            chk("drop_no_hdr2", udp_header_V_TVALID, 0);
            chk("drop_no_pay", udp_payload_TVALID, 0);
            chk("drop_reqrdy", tx_req_V_TREADY, 1);
            chk("drop_stat_sent", stat_sent, sent_exp);
        end else begin
            check_out(f, v);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h1234_5678_C0A8_0102, 3, 8'h0F, 0, 16'h001C, 1'b0, 0};
        vecs[1] = '{64'hAAAA_BBBB_0A00_0002, 1, 8'h01, 0, 16'h0009, 1'b0, 1};
        vecs[2] = '{64'h1111_2222_0A00_0003, 6, 8'hFF, 0, 16'h0000, 1'b1, 0};
        vecs[3] = '{64'h3333_4444_0A00_0004, 2, 8'hFF, 0, 16'h0018, 1'b0, 0};
        vecs[4] = '{64'h5555_6666_0A00_0005, 3, 8'hFF, 2, 16'h0000, 1'b1, 0};
        vecs[5] = '{64'h7777_8888_0A00_0006, 4, 8'h07, 0, 16'h0023, 1'b0, 1};
        vecs[6] = '{64'h9999_AAAA_0A00_0007, 1, 8'h00, 0, 16'h0008, 1'b0, 0};

        // Reset state
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        chk("rst_req_ready", tx_req_V_TREADY, 0);
        chk("rst_pay_ready", tx_payload_TREADY, 0);
        chk("rst_hdr_valid", udp_header_V_TVALID, 0);
        chk("rst_pay_valid", udp_payload_TVALID, 0);
        chk("rst_stat_sent", stat_sent, 0);
        chk("rst_stat_drop", stat_drop, 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_req_ready", tx_req_V_TREADY, 1);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of DRAIN
        drive_frame(10, vecs[0]);
        chk("mid_hdr_valid", udp_header_V_TVALID, 1);
        udp_header_V_TREADY = 1'b1;
        @(negedge ap_clk);
        udp_header_V_TREADY = 1'b0;
        udp_payload_TREADY = 1'b1;
        chk("mid_first_beat", udp_payload_TVALID, 1);
        @(negedge ap_clk);
        udp_payload_TREADY = 1'b0;
        chk("mid_still_draining", udp_payload_TVALID, 1);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("mid_rst_pay_valid", udp_payload_TVALID, 0);
        chk("mid_rst_hdr_valid", udp_header_V_TVALID, 0);
        chk("mid_rst_req_ready", tx_req_V_TREADY, 0);
        chk("mid_rst_stat_sent", stat_sent, 0);
        chk("mid_rst_stat_drop", stat_drop, 0);
        ap_rst_n = 1'b1;
        sent_exp = 0;
        @(negedge ap_clk);
        chk("mid_post_rst_req_ready", tx_req_V_TREADY, 1);
        chk("mid_post_rst_no_drop", stat_drop, 0);
        run_vec(11, vecs[0]);

        // Payload presented before any request
        tx_payload_TDATA  = beat_data(12, 0);
        tx_payload_TKEEP  = 8'hFF;
        tx_payload_TLAST  = 1'b0;
        tx_payload_TVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            chk("early_pay_ready", tx_payload_TREADY, 0);
        end
        run_vec(12, vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
